// File: rtl/coso_beat_counter_if.sv
// CSCnt/CSReq/CSAck handshake between the beat counter (master) and its controller (slave).
interface coso_beat_counter_if #(
  parameter int unsigned CSCntLength = 16
) ();
  logic [CSCntLength-1:0] CSCnt;
  logic                   CSReq;
  logic                   CSAck;

  modport master (output CSCnt, output CSReq, input CSAck);
  modport slave  (input CSCnt, input CSReq, output CSAck);
endinterface

// File: rtl/coso_beat_counter.sv
// Beat-period counter for a coherent-sampling oscillator pair; offers each period as CSCnt.
// Optional glitch filter enabled by defining COSO_GLITCH_FILTER_EN. SyncStages must be >= 2.
module coso_beat_counter #(
  parameter int unsigned            CSCntLength = 16,
  parameter int unsigned            SyncStages  = 2,
  parameter logic [CSCntLength-1:0] MinBeat     = CSCntLength'(4)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                roIn,
  coso_beat_counter_if.master cs,
  output logic                randBit,
  output logic                randValid,
  output logic                overrun,
  output logic                saturated
);

  localparam logic [CSCntLength-1:0] CntMax = '1;

  typedef enum logic {StArm, StRun} state_e;

  state_e                 state_q, state_d;
  logic [SyncStages-1:0]  sync_q, sync_d;
  logic                   dly_q, dly_d;
  logic [CSCntLength-1:0] cnt_q, cnt_d;
  logic [CSCntLength-1:0] cs_cnt_q, cs_cnt_d;
  logic                   cs_req_q, cs_req_d;
  logic                   rand_bit_q, rand_bit_d;
  logic                   rand_valid_q, rand_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   saturated_q, saturated_d;

  logic                   edge_pulse;
  logic                   accept;
  logic                   produce;
  logic [CSCntLength-1:0] cnt_inc;

  assign edge_pulse = sync_q[SyncStages-1] & ~dly_q;
  assign cnt_inc    = (cnt_q == CntMax) ? CntMax : cnt_q + CSCntLength'(1);

`ifdef COSO_GLITCH_FILTER_EN
  // Compare one bit wider so cnt+1 cannot wrap when cnt is all-ones.
  logic [CSCntLength:0] cnt_plus;
  assign cnt_plus = {1'b0, cnt_q} + (CSCntLength+1)'(1);
  assign accept   = edge_pulse && ((state_q == StArm) || (cnt_plus >= {1'b0, MinBeat}));
`else
  logic unused_min_beat;
  assign unused_min_beat = ^MinBeat;
  assign accept          = edge_pulse;
`endif

  always_comb begin
    sync_d      = {sync_q[SyncStages-2:0], roIn};
    dly_d       = sync_q[SyncStages-1];
    state_d     = state_q;
    cnt_d       = cnt_q;
    saturated_d = saturated_q;
    produce     = 1'b0;

    unique case (state_q)
      StArm: begin
        cnt_d = '0;
        if (accept) state_d = StRun;
      end
      StRun: begin
        if (accept) begin
          produce = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntMax) saturated_d = 1'b1;
        end
      end
      default: state_d = StArm;
    endcase
  end

  always_comb begin
    cs_cnt_d     = cs_cnt_q;
    cs_req_d     = cs_req_q & ~cs.CSAck;
    rand_bit_d   = rand_bit_q;
    rand_valid_d = 1'b0;
    overrun_d    = overrun_q;

    if (produce) begin
      // An ack in the same cycle frees the slot, so the new period still loads.
      if (!cs_req_q || cs.CSAck) begin
        cs_cnt_d     = cnt_inc;
        cs_req_d     = 1'b1;
        rand_bit_d   = cnt_inc[0];
        rand_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StArm;
      sync_q       <= '0;
      dly_q        <= 1'b0;
      cnt_q        <= '0;
      cs_cnt_q     <= '0;
      cs_req_q     <= 1'b0;
      rand_bit_q   <= 1'b0;
      rand_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      saturated_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      dly_q        <= dly_d;
      cnt_q        <= cnt_d;
      cs_cnt_q     <= cs_cnt_d;
      cs_req_q     <= cs_req_d;
      rand_bit_q   <= rand_bit_d;
      rand_valid_q <= rand_valid_d;
      overrun_q    <= overrun_d;
      saturated_q  <= saturated_d;
    end
  end

  assign cs.CSCnt  = cs_cnt_q;
  assign cs.CSReq  = cs_req_q;
  assign randBit   = rand_bit_q;
  assign randValid = rand_valid_q;
  assign overrun   = overrun_q;
  assign saturated = saturated_q;

endmodule

// File: tb/tb_coso_beat_counter.sv
// Scoreboard bench for coso_beat_counter: a 16-bit and an 8-bit instance share roIn/rst/CSAck.
module tb_coso_beat_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic roIn = 1'b0;
  logic ack = 1'b0;

  always #5 clk = ~clk;

  coso_beat_counter_if #(.CSCntLength(16)) if16 ();
  coso_beat_counter_if #(.CSCntLength(8))  if8 ();
  assign if16.CSAck = ack;
  assign if8.CSAck  = ack;

  logic rb16, rv16, ov16, sat16;
  logic rb8, rv8, ov8, sat8;

  coso_beat_counter #(.CSCntLength(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .roIn      (roIn),
    .cs        (if16),
    .randBit   (rb16),
    .randValid (rv16),
    .overrun   (ov16),
    .saturated (sat16)
  );

  coso_beat_counter #(.CSCntLength(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .roIn      (roIn),
    .cs        (if8),
    .randBit   (rb8),
    .randValid (rv8),
    .overrun   (ov8),
    .saturated (sat8)
  );

  int n_vec = 0;
  int n_err = 0;
  int q16[$];
  int q8[$];
  bit auto_ack = 1'b0;
  bit own_ack = 1'b0;
  int age = 0;
  int now_n = 0;
  int last_rise = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int p);
    q16.push_back(p);
    q8.push_back((p > 255) ? 255 : p);
  endtask

  task automatic wait_cyc(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      now_n++;
    end
  endtask

  task automatic rise_pulse();
    @(negedge clk);
    now_n++;
    roIn      = 1'b1;
    last_rise = now_n;
    @(negedge clk);
    now_n++;
    roIn = 1'b0;
  endtask

  // Next rise lands exactly n sampling cycles after the previous one.
  task automatic period(input int n, input bit do_push);
    wait_cyc(last_rise + n - 1 - now_n);
    if (do_push) push_exp(n);
    rise_pulse();
  endtask

  // Auto-acknowledge two cycles after CSReq is seen, held for one cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (own_ack) begin
        ack     = 1'b0;
        own_ack = 1'b0;
        age     = 0;
      end else if (auto_ack && if16.CSReq) begin
        age++;
        if (age >= 2) begin
          ack     = 1'b1;
          own_ack = 1'b1;
        end
      end else begin
        age = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rv16) begin
        check("load16_queued", int'(q16.size() > 0), 1);
        if (q16.size() > 0) begin
          int e;
          e = q16.pop_front();
          check("cscnt16", int'(if16.CSCnt), e);
          check("randbit16", int'(rb16), e & 1);
          check("csreq16_on_load", int'(if16.CSReq), 1);
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rv8) begin
        check("load8_queued", int'(q8.size() > 0), 1);
        if (q8.size() > 0) begin
          int e;
          e = q8.pop_front();
          check("cscnt8", int'(if8.CSCnt), e);
          check("randbit8", int'(rb8), e & 1);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wait_cyc(1);
      roIn = ~roIn;
    end
    wait_cyc(1);
    roIn = 1'b0;
    check("rst_cscnt", int'(if16.CSCnt), 0);
    check("rst_csreq", int'(if16.CSReq), 0);
    check("rst_randbit", int'(rb16), 0);
    check("rst_randvalid", int'(rv16), 0);
    check("rst_overrun", int'(ov16), 0);
    check("rst_saturated", int'(sat16), 0);
    check("rst_csreq8", int'(if8.CSReq), 0);
    wait_cyc(1);
    rst = 1'b1;
    wait_cyc(3);

    // First rise only arms the measurement.
    rise_pulse();
    wait_cyc(10);
    check("arm_no_req", int'(if16.CSReq), 0);
    check("arm_no_valid", int'(rv16), 0);

    auto_ack = 1'b1;
    period(100, 1'b1);
    period(100, 1'b1);
    period(37, 1'b1);
    period(37, 1'b1);
    wait_cyc(10);
    check("acked_req_clear", int'(if16.CSReq), 0);
    check("no_overrun_yet", int'(ov16), 0);
    check("randbit_37", int'(rb16), 1);

    // Backpressure: second period is dropped.
    auto_ack = 1'b0;
    period(20, 1'b1);
    period(20, 1'b0);
    wait_cyc(8);
    check("bp_cscnt", int'(if16.CSCnt), 20);
    check("bp_req_held", int'(if16.CSReq), 1);
    check("bp_overrun", int'(ov16), 1);
    check("bp_overrun8", int'(ov8), 1);
    wait_cyc(1);
    ack = 1'b1;
    wait_cyc(1);
    ack = 1'b0;
    check("bp_req_cleared", int'(if16.CSReq), 0);

    // Ack lands in the exact cycle the next period is produced.
    period(25, 1'b1);
    wait_cyc(last_rise + 25 - 1 - now_n);
    push_exp(25);
    rise_pulse();
    wait_cyc(1);
    ack = 1'b1;
    wait_cyc(1);
    ack = 1'b0;
    check("sim_req_held", int'(if16.CSReq), 1);
    check("sim_cscnt", int'(if16.CSCnt), 25);
    check("sim_valid", int'(rv16), 1);
    check("sim_overrun_same", int'(ov16), 1);

    // Saturation on the 8-bit instance.
    auto_ack = 1'b1;
    period(300, 1'b1);
    period(300, 1'b1);
    wait_cyc(8);
    check("sat_cscnt8", int'(if8.CSCnt), 255);
    check("sat_flag8", int'(sat8), 1);
    check("sat_flag16", int'(sat16), 0);
    check("sat_cscnt16", int'(if16.CSCnt), 300);

    // Reset mid-count returns to arm.
    wait_cyc(50);
    rst = 1'b0;
    wait_cyc(1);
    check("midrst_overrun", int'(ov16), 0);
    check("midrst_sat8", int'(sat8), 0);
    check("midrst_cscnt", int'(if16.CSCnt), 0);
    rst = 1'b1;
    wait_cyc(2);
    rise_pulse();
    wait_cyc(20);
    check("rearm_no_req", int'(if16.CSReq), 0);
    check("rearm_no_req8", int'(if8.CSReq), 0);
    period(40, 1'b1);

    // Edges at t=0, 2, 50.
`ifdef COSO_GLITCH_FILTER_EN
    period(2, 1'b0);
    push_exp(50);
    period(48, 1'b0);
`else
    period(2, 1'b1);
    period(48, 1'b1);
`endif
    wait_cyc(20);
    check("drain16", q16.size(), 0);
    check("drain8", q8.size(), 0);
    check("final_req", int'(if16.CSReq), 0);
    check("final_overrun", int'(ov16), 0);
    check("final_sat8", int'(sat8), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coso_beat_counter.md
Name: coso_beat_counter

Overview:
- Producer end of the CSCnt/CSReq/CSAck handshake that the matching controller consumes.
- Clocked by one ring oscillator (RO1 output used as clk). It samples the other oscillator's raw output (RO0) and measures the beat period in clk cycles.
- Each measured period is offered to the controller as CSCnt with a req/ack handshake.
- Also emits the period LSB as the raw TRNG bit.

Parameters:
- CSCntLength, 16, width of the beat counter and of CSCnt.
- SyncStages, 2, number of flip-flops sampling roIn (minimum 2).
- MinBeat, 4, glitch-filter window in cycles. Width is CSCntLength. Used only with COSO_GLITCH_FILTER_EN.

Ports:
- clk  input  1  sampling clock (RO1 output).
- rst  input  1  asynchronous, active-low reset: 0 resets, 1 runs.
- roIn  input  1  raw sampled oscillator (RO0), asynchronous to clk.
- CSAck  input  1  controller acknowledge; value has been read.
- CSCnt  output  CSCntLength  last measured beat period.
- CSReq  output  1  new CSCnt value is valid and unread.
- randBit  output  1  CSCnt[0] of the latest accepted period.
- randValid  output  1  one-cycle strobe with each new randBit.
- overrun  output  1  sticky: a period was dropped because CSReq was still pending.
- saturated  output  1  sticky: the counter hit all-ones.

Behaviour:
- Reset (rst=0, asynchronous):
  - All synchronizer flops, counter and CSCnt = 0.
  - CSReq, randBit, randValid, overrun, saturated = 0.
  - FSM = ARM.
  - Release is synchronous to the next clk edge.
- Sampling and edge detect:
  - roIn passes through a SyncStages-deep shift register, plus one delay flop.
  - A rising-edge pulse `edge` = last stage 1 AND delay flop 0.
  - `edge` is high SyncStages+1 clk edges after roIn is first sampled high.
- Counter:
  - `cnt` increments every cycle and saturates at 2^CSCntLength-1; saturation sets `saturated`.
  - On an accepted edge, period = `cnt`+1 (saturating), then `cnt` is set to 0 in the same cycle.
  - Two accepted edges N cycles apart give period N.
- FSM:
  - ARM: `cnt` is held at 0. The first accepted edge moves to RUN and produces no request; there is no valid previous edge.
  - RUN: every accepted edge produces a period.
  - No other states. Reset returns to ARM from any state mid-measurement; the partial period is discarded.
- Handshake (producer rules):
  - Period produced while CSReq=0: register CSCnt=period, CSReq=1, randBit=period[0], randValid=1 for exactly one cycle, all in the following cycle.
  - CSReq, once high, stays high with CSCnt stable until CSAck is sampled 1. CSReq is cleared on that clk edge.
  - CSAck while CSReq=0 is ignored.
  - Period produced while CSReq=1 and CSAck=0: the period is discarded, CSCnt is unchanged, overrun=1, and no randValid strobe.
  - Period produced in the same cycle CSAck=1 clears an existing request: the new period is loaded, CSReq stays 1, randValid pulses. This counts as load, not overrun.
  - CSReq is never dropped without CSAck except by reset.
- Sticky flags: overrun and saturated clear only on reset.
- Counter wrap: never wraps; it holds at all-ones until the next accepted edge.

Optional Feature:
- Macro COSO_GLITCH_FILTER_EN.
- Defined: an edge in RUN is accepted only if `cnt`+1 >= MinBeat. Rejected edges leave `cnt` counting, produce nothing, and set no flags. In ARM every edge is accepted.
- Undefined: every `edge` pulse is accepted; MinBeat is unused.

Test Plan:
- Reset: hold rst=0 with roIn toggling -> all outputs 0. After release, the first roIn rise only arms: no CSReq.
- Period measurement: roIn rising edges 100 clk cycles apart, CSAck returned 2 cycles after each CSReq -> CSCnt=100, CSReq=1 per edge, randBit=0, randValid one cycle each. Repeat with 37 cycles -> CSCnt=37, randBit=1.
- Backpressure: period 20, CSAck held 0 -> CSCnt stays 20, CSReq stays high, overrun=1 after the next edge. Then CSAck=1 for one cycle -> CSReq=0 on that edge.
- Simultaneous events: CSAck=1 in the exact cycle the next period (25) is produced -> CSReq stays 1, CSCnt=25, overrun unchanged.
- Saturation: CSCntLength=8, edges 300 cycles apart -> CSCnt=255, saturated=1. Mid-count rst pulse -> FSM back to ARM; the next edge produces no CSReq.
- Glitch filter (COSO_GLITCH_FILTER_EN, MinBeat=4): edges at t=0, 2, 50 -> single CSCnt=50. Without the macro -> CSCnt=2 then overrun if unacked, or 48 if acked.
